// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-access pipeline stage.
package mem_pkg;

   localparam int unsigned XLEN = 32;
   localparam int unsigned BE_W = 4;

   typedef logic [1:0] mem_state_t;
   localparam mem_state_t IDLE = 2'd0;
   localparam mem_state_t WAIT = 2'd1;
   localparam mem_state_t HOLD = 2'd2;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Request payload held stable while a data-memory access is outstanding.
   typedef struct packed {
      logic            we;
      logic [BE_W-1:0] be;
      logic [XLEN-1:0] wdata;
   } dmem_cmd_t;

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Byte-lane steering for stores, legality checks, and load extraction.
module lsu_align
   import mem_pkg::*;
(
   input  logic [1:0]      addr_lo_i,
   input  logic [2:0]      funct3_i,
   input  logic            is_load_i,
   input  logic            is_store_i,
   input  logic [XLEN-1:0] rs2_i,
   input  logic [XLEN-1:0] rdata_i,
   output logic [BE_W-1:0] be_o,
   output logic [XLEN-1:0] wdata_o,
   output logic [XLEN-1:0] load_data_o,
   output logic            aligned_o,
   output logic            legal_o
);

   logic            enc_ok;
   logic [XLEN-1:0] shifted;

   // Lane enables and replicated store data by access size.
   always_comb begin
      be_o      = 4'b1111;
      wdata_o   = rs2_i;
      aligned_o = 1'b1;
      case (funct3_i[1:0])
         2'b00: begin
            be_o    = 4'b0001 << addr_lo_i;
            wdata_o = {4{rs2_i[7:0]}};
         end
         2'b01: begin
            be_o      = 4'b0011 << addr_lo_i;
            wdata_o   = {2{rs2_i[15:0]}};
            aligned_o = ~addr_lo_i[0];
         end
         default: begin
            be_o      = 4'b1111;
            aligned_o = (addr_lo_i == 2'b00);
         end
      endcase
   end

   // Unsigned variants only exist for loads.
   always_comb begin
      enc_ok = 1'b0;
      case (funct3_i)
         F3_B, F3_H, F3_W: enc_ok = 1'b1;
         F3_BU, F3_HU:     enc_ok = is_load_i;
         default:          enc_ok = 1'b0;
      endcase
   end

   assign legal_o = enc_ok & aligned_o & ~(is_load_i & is_store_i);

   always_comb begin
      shifted     = rdata_i >> {addr_lo_i, 3'b000};
      load_data_o = rdata_i;
      case (funct3_i)
         F3_B:    load_data_o = {{24{shifted[7]}}, shifted[7:0]};
         F3_H:    load_data_o = {{16{shifted[15]}}, shifted[15:0]};
         F3_BU:   load_data_o = {24'd0, shifted[7:0]};
         F3_HU:   load_data_o = {16'd0, shifted[15:0]};
         default: load_data_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: single-outstanding dmem port plus MEM/WB register.
module mem_stage
   import mem_pkg::*;
#(
   parameter int unsigned ADDR_W = 32
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall_in,
   input  logic [XLEN-1:0]   alu_result_in,
   input  logic [XLEN-1:0]   rs2_in,
   input  logic [4:0]        rd_addr_in,
   input  logic [2:0]        funct3_in,
   input  logic              RegWrite_in,
   input  logic              MemRead_in,
   input  logic              MemWrite_in,
   input  logic              MemtoReg_in,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [XLEN-1:0]   dmem_wdata,
   output logic [BE_W-1:0]   dmem_be,
   input  logic              dmem_ack,
   input  logic [XLEN-1:0]   dmem_rdata,
   output logic [XLEN-1:0]   alu_result_out,
   output logic [XLEN-1:0]   mem_data_out,
   output logic [4:0]        rd_addr_out,
   output logic              RegWrite_out,
   output logic              MemtoReg_out,
   output logic              stall_out,
   output logic              access_err_out,
   output logic [XLEN-1:0]   fault_addr_out
);

   mem_state_t        state_q, state_d;
   logic              req_q, req_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   dmem_cmd_t         cmd_q, cmd_d;
   logic [XLEN-1:0]   buf_q, buf_d;
   logic [XLEN-1:0]   alu_q, alu_d, mdata_q, mdata_d, fault_q, fault_d;
   logic [4:0]        rd_q, rd_d;
   logic              rw_q, rw_d, m2r_q, m2r_d, err_q, err_d;

   logic              mem_op, legal, aligned;
   logic [BE_W-1:0]   be;
   logic [XLEN-1:0]   wdata, load_data, ld_val;
   logic              wb_take, wb_bub;
   logic [XLEN-1:0]   wb_mdata;

   assign mem_op = MemRead_in | MemWrite_in;
   assign ld_val = MemRead_in ? load_data : '0;

   lsu_align u_align (
      .addr_lo_i   (alu_result_in[1:0]),
      .funct3_i    (funct3_in),
      .is_load_i   (MemRead_in),
      .is_store_i  (MemWrite_in),
      .rs2_i       (rs2_in),
      .rdata_i     (dmem_rdata),
      .be_o        (be),
      .wdata_o     (wdata),
      .load_data_o (load_data),
      .aligned_o   (aligned),
      .legal_o     (legal)
   );

   // Next-state, request and write-back control.
   always_comb begin
      state_d   = state_q;
      req_d     = req_q;
      addr_d    = addr_q;
      cmd_d     = cmd_q;
      buf_d     = buf_q;
      err_d     = 1'b0;
      fault_d   = fault_q;
      stall_out = 1'b0;
      wb_take   = 1'b0;
      wb_bub    = 1'b0;
      wb_mdata  = '0;
      case (state_q)
         IDLE: begin
            if (!mem_op) begin
               wb_take = !stall_in;
            end else if (!legal) begin
               if (!stall_in) begin
                  wb_bub  = 1'b1;
                  err_d   = 1'b1;
                  fault_d = alu_result_in;
               end
            end else begin
               stall_out = 1'b1;
               if (!stall_in) begin
                  addr_d  = alu_result_in[ADDR_W-1:0];
                  cmd_d   = '{we: MemWrite_in, be: be, wdata: wdata};
                  req_d   = 1'b1;
                  wb_bub  = 1'b1;
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            stall_out = 1'b1;
            if (dmem_ack) begin
               req_d = 1'b0;
               if (!stall_in) begin
                  stall_out = 1'b0;
                  wb_take   = 1'b1;
                  wb_mdata  = ld_val;
                  state_d   = IDLE;
               end else begin
                  buf_d   = ld_val;
                  state_d = HOLD;
               end
            end
         end
         HOLD: begin
            stall_out = stall_in;
            if (!stall_in) begin
               wb_take  = 1'b1;
               wb_mdata = buf_q;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // MEM/WB register next values; a bubble clears the whole entry.
   always_comb begin
      alu_d   = alu_q;
      mdata_d = mdata_q;
      rd_d    = rd_q;
      rw_d    = rw_q;
      m2r_d   = m2r_q;
      if (wb_take) begin
         alu_d   = alu_result_in;
         mdata_d = wb_mdata;
         rd_d    = rd_addr_in;
         rw_d    = RegWrite_in;
         m2r_d   = MemtoReg_in;
      end else if (wb_bub) begin
         alu_d   = '0;
         mdata_d = '0;
         rd_d    = '0;
         rw_d    = 1'b0;
         m2r_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         req_q   <= 1'b0;
         addr_q  <= '0;
         cmd_q   <= '0;
         buf_q   <= '0;
         alu_q   <= '0;
         mdata_q <= '0;
         rd_q    <= '0;
         rw_q    <= 1'b0;
         m2r_q   <= 1'b0;
         err_q   <= 1'b0;
         fault_q <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         addr_q  <= addr_d;
         cmd_q   <= cmd_d;
         buf_q   <= buf_d;
         alu_q   <= alu_d;
         mdata_q <= mdata_d;
         rd_q    <= rd_d;
         rw_q    <= rw_d;
         m2r_q   <= m2r_d;
         err_q   <= err_d;
         fault_q <= fault_d;
      end
   end

   assign dmem_req       = req_q;
   assign dmem_we        = cmd_q.we;
   assign dmem_addr      = {addr_q[ADDR_W-1:2], 2'b00};
   assign dmem_wdata     = cmd_q.wdata;
   assign dmem_be        = cmd_q.be;
   assign alu_result_out = alu_q;
   assign mem_data_out   = mdata_q;
   assign rd_addr_out    = rd_q;
   assign RegWrite_out   = rw_q;
   assign MemtoReg_out   = m2r_q;
   assign access_err_out = err_q;
   assign fault_addr_out = fault_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a write-back scoreboard queue.
module tb_mem_stage;

   logic        clk, rst_n, stall_in;
   logic [31:0] alu_result_in, rs2_in;
   logic [4:0]  rd_addr_in;
   logic [2:0]  funct3_in;
   logic        RegWrite_in, MemRead_in, MemWrite_in, MemtoReg_in;
   logic        dmem_req, dmem_we, dmem_ack;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_be;
   logic [31:0] alu_result_out, mem_data_out, fault_addr_out;
   logic [4:0]  rd_addr_out;
   logic        RegWrite_out, MemtoReg_out, stall_out, access_err_out;

   typedef struct {
      logic [31:0] alu;
      logic [31:0] mem;
      logic [4:0]  rd;
      logic        rw;
      logic        m2r;
   } wb_t;

   wb_t exp_q[$];
   int  n_vec = 0;
   int  n_err = 0;

   int          stalls, req_cycles;
   logic        cap_req, cap_we, cap_rw;
   logic [31:0] cap_addr, cap_wdata;
   logic [3:0]  cap_be;

   mem_stage #(.ADDR_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .stall_in(stall_in),
      .alu_result_in(alu_result_in), .rs2_in(rs2_in), .rd_addr_in(rd_addr_in),
      .funct3_in(funct3_in), .RegWrite_in(RegWrite_in), .MemRead_in(MemRead_in),
      .MemWrite_in(MemWrite_in), .MemtoReg_in(MemtoReg_in),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
      .dmem_rdata(dmem_rdata), .alu_result_out(alu_result_out),
      .mem_data_out(mem_data_out), .rd_addr_out(rd_addr_out),
      .RegWrite_out(RegWrite_out), .MemtoReg_out(MemtoReg_out),
      .stall_out(stall_out), .access_err_out(access_err_out),
      .fault_addr_out(fault_addr_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      chk(tag, 32'(obs), 32'(exp));
   endtask

   // Reference load extraction: pick the lane, then extend arithmetically.
   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                              input logic [31:0] rd);
      logic [7:0]  b;
      logic [15:0] h;
      int          sh;
      sh = 8 * int'(addr[1:0]);
      b  = 8'(rd >> sh);
      h  = 16'(rd >> sh);
      case (f3)
         3'b000:  return (b >= 8'h80) ? 32'(b) - 32'h100 : 32'(b);
         3'b001:  return (h >= 16'h8000) ? 32'(h) - 32'h10000 : 32'(h);
         3'b100:  return 32'(b);
         3'b101:  return 32'(h);
         default: return rd;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rd,
                        input logic [2:0] f3, input logic rw, input logic mr,
                        input logic mw, input logic m2r);
      alu_result_in = alu; rs2_in = rs2; rd_addr_in = rd; funct3_in = f3;
      RegWrite_in = rw; MemRead_in = mr; MemWrite_in = mw; MemtoReg_in = m2r;
   endtask

   task automatic nop();
      drive(32'h0, 32'h0, 5'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic push_wb(input logic [31:0] alu, input logic [31:0] mem, input logic [4:0] rd,
                          input logic rw, input logic m2r);
      wb_t e;
      e.alu = alu; e.mem = mem; e.rd = rd; e.rw = rw; e.m2r = m2r;
      exp_q.push_back(e);
   endtask

   task automatic check_wb(input string tag);
      wb_t e;
      n_vec++;
      assert (exp_q.size() != 0) else begin
         n_err++;
         $error("FAIL %s_sb: observed empty scoreboard expected an entry", tag);
      end
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         chk({tag, "_alu"}, alu_result_out, e.alu);
         chk({tag, "_mem"}, mem_data_out, e.mem);
         chk({tag, "_rd"}, 32'(rd_addr_out), 32'(e.rd));
         chk1({tag, "_rw"}, RegWrite_out, e.rw);
         chk1({tag, "_m2r"}, MemtoReg_out, e.m2r);
      end
   endtask

   // Issue the driven op, wait ack_dly ack-less WAIT cycles, then ack once.
   task automatic mem_access(input int ack_dly, input logic [31:0] rdata);
      stalls = 0;
      req_cycles = 0;
      #1;
      if (stall_out) stalls++;
      tick();
      cap_req = dmem_req; cap_we = dmem_we; cap_addr = dmem_addr;
      cap_be = dmem_be; cap_wdata = dmem_wdata; cap_rw = RegWrite_out;
      for (int c = 0; c < ack_dly; c++) begin
         #1;
         if (dmem_req) req_cycles++;
         if (stall_out) stalls++;
         tick();
      end
      dmem_ack = 1'b1;
      dmem_rdata = rdata;
      #1;
      if (dmem_req) req_cycles++;
      if (stall_out) stalls++;
      tick();
      dmem_ack = 1'b0;
      dmem_rdata = 32'h0;
   endtask

   initial begin
      rst_n = 1'b1; stall_in = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
      nop();
      #1 rst_n = 1'b0;
      #1;
      chk1("rst_req", dmem_req, 1'b0);
      chk("rst_alu", alu_result_out, 32'h0);
      chk1("rst_rw", RegWrite_out, 1'b0);
      chk1("rst_err", access_err_out, 1'b0);
      chk("rst_fault", fault_addr_out, 32'h0);
      #10 rst_n = 1'b1;
      tick();

      // Plain ALU op passes in one cycle; stall_in freezes the WB register.
      drive(32'h1111_2222, 32'h0, 5'd5, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
      push_wb(32'h1111_2222, 32'h0, 5'd5, 1'b1, 1'b0);
      #1 chk1("alu_stall", stall_out, 1'b0);
      tick();
      check_wb("alu");
      drive(32'hAAAA_5555, 32'h0, 5'd6, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
      stall_in = 1'b1;
      tick();
      chk("hold_alu", alu_result_out, 32'h1111_2222);
      stall_in = 1'b0;
      push_wb(32'hAAAA_5555, 32'h0, 5'd6, 1'b1, 1'b0);
      tick();
      check_wb("alu2");

      // LW at 0x100, ack three cycles after the request rises.
      drive(32'h100, 32'h0, 5'd7, 3'b010, 1'b1, 1'b1, 1'b0, 1'b1);
      push_wb(32'h100, model_load(3'b010, 32'h100, 32'hDEAD_BEEF), 5'd7, 1'b1, 1'b1);
      mem_access(3, 32'hDEAD_BEEF);
      chk("lw_stalls", 32'(stalls), 32'd4);
      chk("lw_req_cycles", 32'(req_cycles), 32'd4);
      chk1("lw_req", cap_req, 1'b1);
      chk1("lw_we", cap_we, 1'b0);
      chk("lw_addr", cap_addr, 32'h100);
      chk("lw_be", 32'(cap_be), 32'hF);
      chk1("lw_bubble", cap_rw, 1'b0);
      check_wb("lw");
      chk1("lw_req_drop", dmem_req, 1'b0);

      // Sub-word loads, signed and unsigned.
      drive(32'h1003, 32'h0, 5'd8, 3'b000, 1'b1, 1'b1, 1'b0, 1'b1);
      push_wb(32'h1003, model_load(3'b000, 32'h1003, 32'h80FF_FFFF), 5'd8, 1'b1, 1'b1);
      mem_access(0, 32'h80FF_FFFF);
      chk("lb_stalls", 32'(stalls), 32'd1);
      chk("lb_be", 32'(cap_be), 32'h8);
      chk("lb_addr", cap_addr, 32'h1000);
      check_wb("lb");
      chk("lb_val", mem_data_out, 32'hFFFF_FF80);
      drive(32'h1003, 32'h0, 5'd9, 3'b100, 1'b1, 1'b1, 1'b0, 1'b1);
      push_wb(32'h1003, model_load(3'b100, 32'h1003, 32'h80FF_FFFF), 5'd9, 1'b1, 1'b1);
      mem_access(1, 32'h80FF_FFFF);
      check_wb("lbu");
      chk("lbu_val", mem_data_out, 32'h0000_0080);
      drive(32'h102, 32'h0, 5'd10, 3'b001, 1'b1, 1'b1, 1'b0, 1'b1);
      push_wb(32'h102, model_load(3'b001, 32'h102, 32'h8001_1234), 5'd10, 1'b1, 1'b1);
      mem_access(0, 32'h8001_1234);
      chk("lh_be", 32'(cap_be), 32'hC);
      check_wb("lh");
      drive(32'h102, 32'h0, 5'd11, 3'b101, 1'b1, 1'b1, 1'b0, 1'b1);
      push_wb(32'h102, model_load(3'b101, 32'h102, 32'h8001_1234), 5'd11, 1'b1, 1'b1);
      mem_access(2, 32'h8001_1234);
      check_wb("lhu");

      // Stores: lane enables, replication, word-aligned address.
      drive(32'h102, 32'h1234_ABCD, 5'd0, 3'b001, 1'b0, 1'b0, 1'b1, 1'b0);
      push_wb(32'h102, 32'h0, 5'd0, 1'b0, 1'b0);
      mem_access(1, 32'h0);
      chk1("sh_we", cap_we, 1'b1);
      chk("sh_be", 32'(cap_be), 32'hC);
      chk("sh_wdata", cap_wdata, 32'hABCD_ABCD);
      chk("sh_addr", cap_addr, 32'h100);
      check_wb("sh");
      drive(32'h101, 32'h0000_00A5, 5'd0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
      push_wb(32'h101, 32'h0, 5'd0, 1'b0, 1'b0);
      mem_access(0, 32'h0);
      chk("sb_be", 32'(cap_be), 32'h2);
      chk("sb_wdata", cap_wdata, 32'hA5A5_A5A5);
      check_wb("sb");
      drive(32'h200, 32'hCAFE_F00D, 5'd0, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0);
      push_wb(32'h200, 32'h0, 5'd0, 1'b0, 1'b0);
      mem_access(0, 32'h0);
      chk("sw_be", 32'(cap_be), 32'hF);
      chk("sw_wdata", cap_wdata, 32'hCAFE_F00D);
      check_wb("sw");

      // Faulting accesses: misaligned, bad funct3, read+write together.
      drive(32'h101, 32'h0, 5'd12, 3'b010, 1'b1, 1'b1, 1'b0, 1'b1);
      tick();
      chk1("mis_req", dmem_req, 1'b0);
      chk1("mis_err", access_err_out, 1'b1);
      chk("mis_fault", fault_addr_out, 32'h101);
      chk1("mis_rw", RegWrite_out, 1'b0);
      nop();
      tick();
      chk1("mis_err_pulse", access_err_out, 1'b0);
      chk1("mis_req2", dmem_req, 1'b0);
      drive(32'h200, 32'h0, 5'd12, 3'b011, 1'b1, 1'b1, 1'b0, 1'b1);
      tick();
      chk1("f3_err", access_err_out, 1'b1);
      chk("f3_fault", fault_addr_out, 32'h200);
      drive(32'h4, 32'h0, 5'd12, 3'b000, 1'b1, 1'b1, 1'b1, 1'b0);
      tick();
      chk1("rw_err", access_err_out, 1'b1);
      chk("rw_fault", fault_addr_out, 32'h4);
      chk1("rw_req", dmem_req, 1'b0);
      nop();
      tick();

      // Ack while stalled parks data in HOLD; a second ack there is ignored.
      drive(32'h300, 32'h0, 5'd9, 3'b010, 1'b1, 1'b1, 1'b0, 1'b1);
      push_wb(32'h300, model_load(3'b010, 32'h300, 32'h0BAD_F00D), 5'd9, 1'b1, 1'b1);
      #1 chk1("hold_issue_stall", stall_out, 1'b1);
      tick();
      chk1("hold_req", dmem_req, 1'b1);
      stall_in = 1'b1; dmem_ack = 1'b1; dmem_rdata = 32'h0BAD_F00D;
      #1 chk1("hold_ack_stall", stall_out, 1'b1);
      tick();
      chk1("hold_req_drop", dmem_req, 1'b0);
      chk1("hold_wb_frozen", RegWrite_out, 1'b0);
      dmem_rdata = 32'hFFFF_FFFF;
      #1 chk1("hold_stall", stall_out, 1'b1);
      tick();
      dmem_ack = 1'b0; dmem_rdata = 32'h0; stall_in = 1'b0;
      chk1("hold_wb_frozen2", RegWrite_out, 1'b0);
      #1 chk1("hold_release_stall", stall_out, 1'b0);
      tick();
      check_wb("hold");
      chk1("hold_req_idle", dmem_req, 1'b0);
      nop();

      // Reset in WAIT clears everything at once; a late ack is ignored.
      drive(32'h400, 32'h0, 5'd11, 3'b010, 1'b1, 1'b1, 1'b0, 1'b1);
      tick();
      chk1("rst2_req_pre", dmem_req, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk1("rst2_req", dmem_req, 1'b0);
      chk("rst2_fault", fault_addr_out, 32'h0);
      chk1("rst2_rw", RegWrite_out, 1'b0);
      chk("rst2_mem", mem_data_out, 32'h0);
      nop();
      #2 rst_n = 1'b1;
      drive(32'h77, 32'h0, 5'd3, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
      dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678;
      push_wb(32'h77, 32'h0, 5'd3, 1'b1, 1'b0);
      #1 chk1("rst2_alu_stall", stall_out, 1'b0);
      tick();
      dmem_ack = 1'b0; dmem_rdata = 32'h0;
      check_wb("rst2_alu");
      chk1("rst2_req_after", dmem_req, 1'b0);
      nop();
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
